// File: rtl/fifo_queue_pkg.sv
// Shared sizing helpers and parameter legality rules for the parametrised FIFO.
package fifo_queue_pkg;

   function automatic int count_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   function automatic bit params_legal(input int data_width, input int depth,
                                       input int af_level, input int ae_level);
      return (data_width >= 1) && (depth >= 2) &&
             (af_level >= 1) && (af_level <= depth - 1) &&
             (ae_level >= 0) && (ae_level <= depth - 2) &&
             (ae_level < af_level);
   endfunction

endpackage

// File: rtl/fifo_queue_mem.sv
// DEPTH x DATA_WIDTH storage with one write port and one registered read port.
module fifo_queue_mem #(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 8,
   parameter int AW         = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   input  logic [AW-1:0]         rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // NOTE: the array has no reset so it can map onto RAM; only the output register is reset.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // NOTE: non-blocking read returns the old entry when the same slot is written this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/fifo_queue_param.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and sticky errors.
module fifo_queue_param
   import fifo_queue_pkg::*;
#(
   parameter  int DATA_WIDTH         = 8,
   parameter  int DEPTH              = 8,
   parameter  int ALMOST_FULL_LEVEL  = DEPTH - 2,
   parameter  int ALMOST_EMPTY_LEVEL = 2,
   localparam int CW                 = count_width(DEPTH)
) (
   input  logic                  Clk_In,
   input  logic                  Reset_n_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   input  logic                  Write_Enable_In,
   input  logic                  Read_Enable_In,
   input  logic                  Flush_In,
   input  logic                  Clear_Errors_In,
   output logic [DATA_WIDTH-1:0] Data_Out,
   output logic                  Data_Valid_Out,
   output logic                  FIFO_Empty,
   output logic                  FIFO_Full,
   output logic                  Almost_Empty,
   output logic                  Almost_Full,
   output logic [CW-1:0]         Fill_Count,
   output logic                  Overflow_Error,
   output logic                  Underflow_Error
);

   localparam int AW = ptr_width(DEPTH);
   localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);
   localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LEVEL);
   localparam logic [CW-1:0] ONE_CNT  = CW'(1);

   if (!params_legal(DATA_WIDTH, DEPTH, ALMOST_FULL_LEVEL, ALMOST_EMPTY_LEVEL)) begin : g_bad_params
      $error("fifo_queue_param: illegal DATA_WIDTH/DEPTH/ALMOST_FULL_LEVEL/ALMOST_EMPTY_LEVEL");
   end

   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count_next;
   logic          rd_ok, wr_ok, rd_go, wr_go, ovf_set, unf_set;

   function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] ptr);
      return (ptr == LAST_PTR) ? '0 : ptr + AW'(1);
   endfunction

   // Flush suppresses the transfers and the errors that would otherwise be raised.
   assign rd_ok   = Read_Enable_In & ~FIFO_Empty;
   assign wr_ok   = Write_Enable_In & (~FIFO_Full | rd_ok);
   assign rd_go   = rd_ok & ~Flush_In;
   assign wr_go   = wr_ok & ~Flush_In;
   assign ovf_set = Write_Enable_In & ~wr_ok & ~Flush_In;
   assign unf_set = Read_Enable_In & ~rd_ok & ~Flush_In;

   // NOTE: default first so every path assigns count_next and no latch is inferred.
   always_comb begin
      count_next = Fill_Count;
      if (Flush_In)            count_next = '0;
      else if (wr_go & ~rd_go) count_next = Fill_Count + ONE_CNT;
      else if (rd_go & ~wr_go) count_next = Fill_Count - ONE_CNT;
   end

   always_ff @(posedge Clk_In or negedge Reset_n_In) begin
      if (!Reset_n_In) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         Fill_Count      <= '0;
         Data_Valid_Out  <= 1'b0;
         FIFO_Empty      <= 1'b1;
         FIFO_Full       <= 1'b0;
         Almost_Empty    <= 1'b1;
         Almost_Full     <= 1'b0;
         Overflow_Error  <= 1'b0;
         Underflow_Error <= 1'b0;
      end else begin
         if (Flush_In) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_go) wr_ptr <= next_ptr(wr_ptr);
            if (rd_go) rd_ptr <= next_ptr(rd_ptr);
         end
         // Flags come from count_next so they move on the same edge as the count.
         Fill_Count      <= count_next;
         FIFO_Empty      <= (count_next == '0);
         FIFO_Full       <= (count_next == FULL_CNT);
         Almost_Empty    <= (count_next <= AE_CNT);
         Almost_Full     <= (count_next >= AF_CNT);
         Data_Valid_Out  <= rd_go;
         Overflow_Error  <= ovf_set | (Overflow_Error  & ~Clear_Errors_In);
         Underflow_Error <= unf_set | (Underflow_Error & ~Clear_Errors_In);
      end
   end

   fifo_queue_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .AW         (AW)
   ) u_mem (
      .clk     (Clk_In),
      .rst_n   (Reset_n_In),
      .wr_en   (wr_go),
      .wr_addr (wr_ptr),
      .wr_data (Data_In),
      .rd_en   (rd_go),
      .rd_addr (rd_ptr),
      .rd_data (Data_Out)
   );

endmodule

// File: tb/tb_fifo_queue_param.sv
// Directed bench for fifo_queue_param with a queue-based reference model checked every cycle.
module tb_fifo_queue_param;

   localparam int DW    = 8;
   localparam int DEPTH = 8;
   localparam int AF    = 6;
   localparam int AE    = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] din = '0;
   logic          we = 1'b0, re = 1'b0, fl = 1'b0, clr = 1'b0;
   logic [DW-1:0] dout;
   logic          dvalid, empty, full, aempty, afull, ovf, unf;
   logic [CW-1:0] fill;

   int checks = 0;
   int failures = 0;

   fifo_queue_param #(
      .DATA_WIDTH         (DW),
      .DEPTH              (DEPTH),
      .ALMOST_FULL_LEVEL  (AF),
      .ALMOST_EMPTY_LEVEL (AE)
   ) dut (
      .Clk_In          (clk),
      .Reset_n_In      (rst_n),
      .Data_In         (din),
      .Write_Enable_In (we),
      .Read_Enable_In  (re),
      .Flush_In        (fl),
      .Clear_Errors_In (clr),
      .Data_Out        (dout),
      .Data_Valid_Out  (dvalid),
      .FIFO_Empty      (empty),
      .FIFO_Full       (full),
      .Almost_Empty    (aempty),
      .Almost_Full     (afull),
      .Fill_Count      (fill),
      .Overflow_Error  (ovf),
      .Underflow_Error (unf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored bytes plus the externally visible registers.
   logic [DW-1:0] m_q[$];
   logic [DW-1:0] m_dout;
   logic          m_valid, m_ovf, m_unf;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q.delete();
         m_dout  = '0;
         m_valid = 1'b0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
      end else begin
         bit r_acc, w_acc, o_set, u_set;
         r_acc = 1'b0; w_acc = 1'b0; o_set = 1'b0; u_set = 1'b0;
         if (fl) begin
            m_q.delete();
         end else begin
            r_acc = re && (m_q.size() > 0);
            w_acc = we && ((m_q.size() < DEPTH) || r_acc);
            if (r_acc) m_dout = m_q.pop_front();
            if (w_acc) m_q.push_back(din);
            o_set = we && !w_acc;
            u_set = re && !r_acc;
         end
         m_valid = r_acc;
         m_ovf   = o_set || (m_ovf && !clr);
         m_unf   = u_set || (m_unf && !clr);
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         check("cmp_data",   dout,   m_dout);
         check("cmp_valid",  dvalid, m_valid);
         check("cmp_count",  fill,   m_q.size());
         check("cmp_empty",  empty,  m_q.size() == 0);
         check("cmp_full",   full,   m_q.size() == DEPTH);
         check("cmp_aempty", aempty, m_q.size() <= AE);
         check("cmp_afull",  afull,  m_q.size() >= AF);
         check("cmp_ovf",    ovf,    m_ovf);
         check("cmp_unf",    unf,    m_unf);
      end
   end

   // One clock: drive on the falling edge, return 1 ns after the rising edge.
   task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d,
                      input logic f, input logic c);
      @(negedge clk);
      we = w; re = r; din = d; fl = f; clr = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      #12;
      check("rst_data",   dout,   8'h00);
      check("rst_valid",  dvalid, 1'b0);
      check("rst_empty",  empty,  1'b1);
      check("rst_full",   full,   1'b0);
      check("rst_aempty", aempty, 1'b1);
      check("rst_afull",  afull,  1'b0);
      check("rst_count",  fill,   0);
      check("rst_errs",   {ovf, unf}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // 1. read from empty, then clear the error
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      check("t1_data",  dout,   8'h00);
      check("t1_valid", dvalid, 1'b0);
      check("t1_unf",   unf,    1'b1);
      check("t1_count", fill,   0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t1_unf_clr", unf, 1'b0);

      // 2. fill to capacity, then overflow
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b1, 1'b0, 8'(8'h11 * i), 1'b0, 1'b0);
         check("t2_count",  fill,   i);
         check("t2_aempty", aempty, i <= 2);
         check("t2_afull",  afull,  i >= 6);
         check("t2_full",   full,   i == 8);
      end
      cyc(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
      check("t2_ovf",   ovf,  1'b1);
      check("t2_count", fill, 8);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
      check("t2_ovf_clr", ovf, 1'b0);

      // 3. drain in order
      for (int i = 1; i <= 8; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         check("t3_data",  dout,   8'(8'h11 * i));
         check("t3_valid", dvalid, 1'b1);
      end
      check("t3_empty", empty, 1'b1);
      idle();
      check("t3_valid_off", dvalid, 1'b0);
      check("t3_hold",      dout,   8'h88);

      // 4. simultaneous read/write while full, across the pointer wrap
      for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 8'(8'h11 * i), 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
         check("t4_count", fill,   8);
         check("t4_full",  full,   1'b1);
         check("t4_ovf",   ovf,    1'b0);
         check("t4_data",  dout,   8'(8'h11 * i));
      end
      for (int i = 4; i <= 11; i++) begin
         cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
         check("t4_drain", dout, (i <= 8) ? 8'(8'h11 * i) : 8'hA5);
      end
      check("t4_empty", empty, 1'b1);

      // 5. simultaneous read/write while empty
      cyc(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
      check("t5_count", fill,   1);
      check("t5_unf",   unf,    1'b1);
      check("t5_valid", dvalid, 1'b0);
      cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
      check("t5_data",  dout,   8'h3C);
      check("t5_valid2", dvalid, 1'b1);

      // 6. flush with a concurrent write, then async reset mid-burst
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i), 1'b0, 1'b0);
      check("t6_pre", fill, 5);
      cyc(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
      check("t6_count", fill,   0);
      check("t6_empty", empty,  1'b1);
      check("t6_ovf",   ovf,    1'b0);
      check("t6_hold",  dout,   8'h3C);
      for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 8'(8'h70 + i), 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      check("t6_unf_set", unf, 1'b1);
      @(negedge clk);
      we = 1'b1; re = 1'b1; din = 8'h7F;
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_data",  dout,   8'h00);
      check("t6_rst_count", fill,   0);
      check("t6_rst_flags", {empty, full, aempty, afull}, 4'b1010);
      check("t6_rst_errs",  {ovf, unf, dvalid}, 3'b000);
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
